counter_event_logger: RTL

// - Downstream of the up/down game counter: consumes its WINNER/LOSER pulses, GAMEOVER and WHO.
// - Also watches the INIT strobe that the testbench drives into the counter.
// - Converts these into timestamped event records, buffers them in a FIFO and drains them over a valid/ready port.
// - Keeps running win/lose/game totals for scoreboards and a status readout.

---
 rtl/counter_evtlog_pkg.sv | 28 ++
 rtl/evt_fifo.sv | 69 ++++++
 rtl/counter_event_logger.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/counter_evtlog_pkg.sv
// Shared types and helpers for the game-counter event logger.
// Record width depends on COUNTER_EVTLOG_TS_EN (timestamp field present when defined).
package counter_evtlog_pkg;

  typedef enum logic [1:0] {
    EVT_INIT = 2'b00,
    EVT_WIN  = 2'b01,
    EVT_LOSE = 2'b10,
    EVT_OVER = 2'b11
  } evt_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } log_state_e;

  // Record width: {code, who} plus the timestamp field when it is built.
  function automatic int evt_w(input int ts_width);
    int w;
    w = ts_width + 4;
`ifndef COUNTER_EVTLOG_TS_EN
    w = 4;
`endif
    return w;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Single-clock synchronous FIFO. The head entry is read straight from the
// storage registers, so a push is visible one cycle after its edge and there
// is no same-cycle bypass. A push into a full FIFO is accepted only when a
// pop happens on the same edge; otherwise it is discarded (caller flags it).
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/counter_event_logger.sv
// Event logger for the up/down game counter: turns INIT/WINNER/LOSER/GAMEOVER
// into records, queues them and keeps running totals.
// Macro COUNTER_EVTLOG_TS_EN adds a timestamp (cycles since last INIT) to each record.
//
// Output handshake: evt_valid high means evt_data holds the oldest record; a
// record is consumed on each rising edge where evt_valid && evt_ready, and
// evt_data stays unchanged while evt_valid && !evt_ready.
module counter_event_logger
  import counter_evtlog_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_WIDTH     = 16,
  localparam int EVT_W = evt_w(TS_WIDTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    INIT,
  input  logic                    WINNER,
  input  logic                    LOSER,
  input  logic                    GAMEOVER,
  input  logic [1:0]              WHO,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [EVT_W-1:0]        evt_data,
  output logic [COUNTER_SIZE-1:0] win_total,
  output logic [COUNTER_SIZE-1:0] lose_total,
  output logic [7:0]              games_done,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    overflow,
  output logic                    proto_err,
  output log_state_e              state_o
);

  log_state_e              state_q, state_d;
  logic                    gameover_q;
  logic [COUNTER_SIZE-1:0] win_q, win_d;
  logic [COUNTER_SIZE-1:0] lose_q, lose_d;
  logic [7:0]              games_q, games_d;
  logic                    ovf_q, perr_q;

  logic                    in_play, ev_over, ev_init, ev_win, ev_lose;
  logic                    push;
  evt_code_e               code;
  logic [1:0]              who;
  logic [EVT_W-1:0]        push_data;
  logic                    fifo_full, fifo_empty, pop;

  assign in_play = (state_q == ST_PLAY);
  assign ev_over = in_play && GAMEOVER && !gameover_q;
  assign ev_init = INIT;
  assign ev_win  = in_play && WINNER;
  assign ev_lose = in_play && LOSER;

  // Arbitration: one record per cycle, OVER > INIT > WIN > LOSE.
  always_comb begin
    push = 1'b1;
    code = EVT_INIT;
    who  = 2'b00;
    if (ev_over) begin
      code = EVT_OVER;
      who  = WHO;
    end else if (ev_init) begin
      code = EVT_INIT;
    end else if (ev_win) begin
      code = EVT_WIN;
    end else if (ev_lose) begin
      code = EVT_LOSE;
    end else begin
      push = 1'b0;
    end
  end

`ifdef COUNTER_EVTLOG_TS_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] rec_ts;

  // Timestamp: cleared by an INIT that wins arbitration, counts in PLAY, saturates.
  always_comb begin
    ts_d = ts_q;
    if (ev_init && !ev_over)                          ts_d = '0;
    else if (in_play && (ts_q != {TS_WIDTH{1'b1}}))   ts_d = ts_q + 1'b1;
  end

  // Timestamp register.
  always_ff @(posedge clk) begin
    if (rst_l) ts_q <= '0;
    else       ts_q <= ts_d;
  end

  assign rec_ts    = (code == EVT_INIT) ? '0 : ts_q;
  assign push_data = {code, who, rec_ts};
`else
  assign push_data = {code, who};
`endif

  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (evt_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM next-state: IDLE waits for INIT, PLAY ends on a GAMEOVER rise,
  // OVER restarts on INIT or retires to IDLE once the queue has drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (INIT) state_d = ST_PLAY;
      ST_PLAY: if (ev_over) state_d = ST_OVER;
      ST_OVER: begin
        if (INIT)            state_d = ST_PLAY;
        else if (fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Totals next-state: counted on every observed event, saturating; a
  // simultaneous WINNER+LOSER counts as a win only.
  always_comb begin
    win_d   = win_q;
    lose_d  = lose_q;
    games_d = games_q;
    if (ev_win && (win_q != {COUNTER_SIZE{1'b1}}))              win_d   = win_q + 1'b1;
    if (ev_lose && !WINNER && (lose_q != {COUNTER_SIZE{1'b1}})) lose_d  = lose_q + 1'b1;
    if (ev_over && (games_q != 8'hFF))                          games_d = games_q + 1'b1;
  end

  // State, edge detector, totals and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      state_q    <= ST_IDLE;
      gameover_q <= 1'b0;
      win_q      <= '0;
      lose_q     <= '0;
      games_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gameover_q <= GAMEOVER;
      win_q      <= win_d;
      lose_q     <= lose_d;
      games_q    <= games_d;
      if (push && fifo_full && !pop) ovf_q  <= 1'b1;
      if (in_play && WINNER && LOSER) perr_q <= 1'b1;
    end
  end

  assign win_total  = win_q;
  assign lose_total = lose_q;
  assign games_done = games_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;
  assign state_o    = state_q;

endmodule
